chrom_evaluator: RTL and testbench

Parametrised fitness-evaluation engine between the HPS PIO bank and the evolved candidate circuit. On a start request it walks up to NUM_SEQ stored input vectors, drives each into the candidate circuit, waits a settle interval, compares masked outputs against expected values and accumulates per-output-channel error counts. It then completes a four-phase done/feedback handshake with software. It generalises the fixed 32-sequence, 8-error-channel PIO arrangement to arbitrary sequence count, I/O widths and settle time, and adds abort handling.

---
 rtl/chrom_eval_pkg.sv | 9 +
 rtl/chrom_evaluator_err_accum.sv | 21 ++
 rtl/chrom_evaluator.sv | 105 ++++++++++
 tb/tb_chrom_evaluator.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/chrom_eval_pkg.sv
// chrom_eval_pkg: shared state encoding and index-width helpers for chrom_evaluator
package chrom_eval_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, SAMPLE, DONE, RELEASE} state_t;
  localparam int NUM_SEQ_DEF = 32;
  localparam int SEQ_IDX_W = $clog2(NUM_SEQ_DEF);
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/chrom_evaluator_err_accum.sv
// err_accum: per-channel error counter; saturates with CHROM_EVAL_SATURATE_EN, wraps otherwise
module err_accum #(
  parameter int ERR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [ERR_W-1:0] cnt
);
`ifdef CHROM_EVAL_SATURATE_EN
  logic bump;
  assign bump = inc && !(&cnt);
`else
  logic bump;
  assign bump = inc;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : bump ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/chrom_evaluator.sv
// chrom_evaluator: walks stored vectors through the candidate circuit and counts masked output errors
// Accumulator overflow set by CHROM_EVAL_SATURATE_EN (saturate) or wrap when undefined.
module chrom_evaluator
  import chrom_eval_pkg::*;
#(
  parameter int NUM_SEQ       = 32,
  parameter int IN_W          = 32,
  parameter int OUT_W         = 8,
  parameter int ERR_W         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic                     start_processing_chrom,
  input  logic                     done_processing_feedback,
  input  logic [31:0]              sequences_to_process,
  input  logic [NUM_SEQ*IN_W-1:0]  input_sequence,
  input  logic [NUM_SEQ*OUT_W-1:0] expected_output,
  input  logic [NUM_SEQ*OUT_W-1:0] valid_output,
  output logic [IN_W-1:0]          circ_in,
  input  logic [OUT_W-1:0]         circ_out,
  output logic                     ready_to_process,
  output logic                     done_processing_chrom,
  output logic [OUT_W*ERR_W-1:0]   error_sum
);
  localparam int IW = idx_w(NUM_SEQ);
  state_t state;
  logic [31:0] count;
  logic [IW-1:0] idx, idx_n;
  logic [15:0] settle;
  logic [OUT_W-1:0] sync1, sync2, mism;
  logic abort, clr, last;
  logic start, fb;
  assign start = start_processing_chrom;
  assign fb = done_processing_feedback;
  assign idx_n = idx + 1'b1;
  assign abort = !start && (state == CLEAR || state == SETTLE || state == SAMPLE);
  assign clr = state == CLEAR || abort;
  assign last = 32'(idx) == count - 32'd1;
  assign mism = (sync2 ^ expected_output[int'(idx)*OUT_W +: OUT_W]) & valid_output[int'(idx)*OUT_W +: OUT_W];
  genvar g;
  for (g = 0; g < OUT_W; g++) begin : g_acc
    err_accum #(.ERR_W(ERR_W)) u_acc (
      .clk(clk_clk),
      .rst_n(reset_reset_n),
      .clr(clr),
      .inc(state == SAMPLE && start && mism[g]),
      .cnt(error_sum[g*ERR_W +: ERR_W])
    );
  end
  // circ_out may be asynchronous to the stimulus, so it is resynchronised
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) {sync2, sync1} <= '0;
    else {sync2, sync1} <= {sync1, circ_out};
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      state <= IDLE;
      ready_to_process <= 1'b0;
      done_processing_chrom <= 1'b0;
      circ_in <= '0;
      count <= '0;
      idx <= '0;
      settle <= '0;
    end else if (abort) begin
      state <= IDLE;
      ready_to_process <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          ready_to_process <= !start;
          if (start) begin
            state <= CLEAR;
            count <= sequences_to_process > 32'(NUM_SEQ) ? 32'(NUM_SEQ) : sequences_to_process;
          end
        end
        CLEAR: begin
          idx <= '0;
          settle <= '0;
          circ_in <= input_sequence[IN_W-1:0];
          state <= count == 32'd0 ? DONE : SETTLE;
        end
        SETTLE:
          if (settle == 16'(SETTLE_CYCLES - 2)) state <= SAMPLE;
          else settle <= settle + 16'd1;
        SAMPLE:
          if (last) state <= DONE;
          else begin
            idx <= idx_n;
            settle <= '0;
            circ_in <= input_sequence[int'(idx_n)*IN_W +: IN_W];
            state <= SETTLE;
          end
        DONE: begin
          done_processing_chrom <= !fb;
          if (fb) state <= RELEASE;
        end
        RELEASE:
          if (!start && !fb) begin
            state <= IDLE;
            ready_to_process <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_chrom_evaluator.sv
// tb_chrom_evaluator: scoreboard bench for chrom_evaluator, incl. abort, reset and overflow cases
module tb_chrom_evaluator;
  logic clk = 1'b0;
  logic rst_n, start, fb, start1, fb1;
  logic [31:0] seq_n, seq1;
  logic [7:0] in_seq, exp_seq, val_seq;
  logic [15:0] in1, exp1, val1;
  logic [1:0] mode, c_in, c_out, c_in1;
  logic ready, done, ready1, done1;
  logic [15:0] esum;
  logic [3:0] esum1;
  int tests = 0, fails = 0;
  typedef struct { logic [15:0] sums; int lat; } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  function automatic logic [1:0] circ(input logic [1:0] m, input logic [1:0] x);
    return m == 2'd0 ? x : m == 2'd1 ? 2'b11 : x ^ 2'b10;
  endfunction
  assign c_out = circ(mode, c_in);
  chrom_evaluator #(.NUM_SEQ(4), .IN_W(2), .OUT_W(2), .ERR_W(8), .SETTLE_CYCLES(4)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .start_processing_chrom(start),
    .done_processing_feedback(fb), .sequences_to_process(seq_n), .input_sequence(in_seq),
    .expected_output(exp_seq), .valid_output(val_seq), .circ_in(c_in), .circ_out(c_out),
    .ready_to_process(ready), .done_processing_chrom(done), .error_sum(esum));
  chrom_evaluator #(.NUM_SEQ(8), .IN_W(2), .OUT_W(2), .ERR_W(2), .SETTLE_CYCLES(4)) dut1 (
    .clk_clk(clk), .reset_reset_n(rst_n), .start_processing_chrom(start1),
    .done_processing_feedback(fb1), .sequences_to_process(seq1), .input_sequence(in1),
    .expected_output(exp1), .valid_output(val1), .circ_in(c_in1), .circ_out(2'b11),
    .ready_to_process(ready1), .done_processing_chrom(done1), .error_sum(esum1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic run(input int n, input logic [1:0] m, input logic [7:0] ins, input logic [7:0] exps,
                     input logic [7:0] vals, input bit hold);
    exp_t e;
    int cnt, lat;
    bit ok;
    logic [1:0] mm;
    @(negedge clk);
    mode = m; in_seq = ins; exp_seq = exps; val_seq = vals; seq_n = n;
    cnt = n > 4 ? 4 : n;
    e.sums = '0;
    for (int k = 0; k < cnt; k++) begin
      mm = (circ(m, ins[2*k +: 2]) ^ exps[2*k +: 2]) & vals[2*k +: 2];
      for (int c = 0; c < 2; c++) if (mm[c]) e.sums[c*8 +: 8] = e.sums[c*8 +: 8] + 8'd1;
    end
    e.lat = 2 + cnt * 4;
    q.push_back(e);
    chk("ready_idle", ready, 1);
    start = 1'b1;
    @(posedge clk);
    lat = 0; ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #1;
      lat++;
      ok = done;
    end
    chk("done_timeout", ok, 1);
    e = q.pop_front();
    chk("latency", lat, e.lat);
    chk("error_sum", esum, e.sums);
    @(negedge clk); fb = 1'b1;
    @(posedge clk); #1;
    chk("done_release", done, 0);
    if (hold) begin
      repeat (3) @(posedge clk);
      #1 chk("hold_release", ready, 0);
    end
    @(negedge clk); start = 1'b0; fb = 1'b0;
    @(posedge clk); #1;
    chk("ready_back", ready, 1);
  endtask
  initial begin
    exp_t e;
    bit seen, ok;
    int lat;
    rst_n = 1'b0; start = 0; fb = 0; start1 = 0; fb1 = 0;
    seq_n = 0; seq1 = 5; mode = 0;
    in_seq = 0; exp_seq = 0; val_seq = 0;
    in1 = '0; exp1 = '0; val1 = 16'h5555;
    #2;
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", esum, 0);
    chk("rst_circ_in", c_in, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_first_edge", ready, 1);
    run(4, 2'd0, 8'b11_10_01_00, 8'b11_10_01_00, 8'hFF, 0);
    run(4, 2'd1, 8'($urandom), 8'h00, 8'h55, 0);
    run(0, 2'd1, 8'($urandom), 8'h00, 8'hFF, 0);
    run(100, 2'd1, 8'($urandom), 8'h00, 8'hFF, 0);
    run(3, 2'd2, 8'($urandom), 8'($urandom), 8'($urandom), 1);
    // abort during the second settle interval
    @(negedge clk);
    mode = 2'd1; in_seq = 8'h1B; exp_seq = 8'h00; val_seq = 8'hFF; seq_n = 4;
    e.sums = '0; e.lat = 0; q.push_back(e);
    start = 1'b1;
    @(posedge clk);
    seen = 0;
    repeat (6) begin @(posedge clk); #1 seen |= done; end
    chk("pre_abort_sum", esum, 16'h0101);
    start = 1'b0;
    @(posedge clk); #1;
    seen |= done;
    e = q.pop_front();
    chk("abort_ready", ready, 1);
    chk("abort_done", seen, 0);
    chk("abort_sum", esum, e.sums);
    // overflow on the narrow-accumulator instance
    @(negedge clk);
`ifdef CHROM_EVAL_SATURATE_EN
    e.sums = 16'h0003;
`else
    e.sums = 16'h0001;
`endif
    e.lat = 22; q.push_back(e);
    start1 = 1'b1;
    @(posedge clk);
    lat = 0; ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin @(posedge clk); #1; lat++; ok = done1; end
    e = q.pop_front();
    chk("ovf_timeout", ok, 1);
    chk("ovf_latency", lat, e.lat);
    chk("ovf_sum", {28'd0, esum1}, {16'd0, e.sums});
    @(negedge clk); fb1 = 1'b1;
    @(negedge clk); start1 = 1'b0; fb1 = 1'b0;
    // reset in the middle of settle must clear outputs without a clock edge
    @(negedge clk);
    mode = 2'd1; in_seq = 8'h01; exp_seq = 8'h00; val_seq = 8'hFF; seq_n = 4;
    start = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 chk("pre_rst_circ_in", c_in, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sum", esum, 0);
    chk("mid_rst_circ_in", c_in, 0);
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", ready, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
